// File: rtl/bitvec_uart_framer_pkg.sv
// ---------------------------------------------------------------------------
// framer_pkg
// Shared constants and types for the bit-vector UART framer.
//   CHR_ZERO / CHR_TERM : ASCII '0' and '*' used on the TX byte stream
//   CUR_W               : width of the TX bit cursor
//   tx_state_t          : TX FSM state encoding
//   bit_chr()           : maps one vector bit to its ASCII digit
// ---------------------------------------------------------------------------
package framer_pkg;

    localparam logic [7:0] CHR_ZERO = 8'd48;
    localparam logic [7:0] CHR_TERM = 8'd42;
    localparam int         CUR_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BITS = 2'd1,
        ST_TERM = 2'd2
    } tx_state_t;

    // '0' is 8'h30, so the bit value simply lands in the LSB.
    function automatic logic [7:0] bit_chr(input logic b);
        return CHR_ZERO | {7'd0, b};
    endfunction

endpackage

// File: rtl/bitvec_rx_decoder.sv
// ---------------------------------------------------------------------------
// bitvec_rx_decoder
// Decodes host command bytes into writes of single bits of rx_vec.
// Command byte: [7:1] = bit index, [0] = bit value.
//   clk_48mhz   in   clock, rising edge
//   reset_n     in   synchronous active-low reset
//   cmd_data    in   8-bit command byte
//   cmd_valid   in   command byte valid
//   cmd_ready   out  block accepts commands (high every cycle after reset)
//   rx_vec      out  IL-bit vector written by commands
//   rx_seen     out  sticky: a legal command has been applied
//   rx_err_cnt  out  saturating count of out-of-range commands
// ---------------------------------------------------------------------------
module bitvec_rx_decoder
    import framer_pkg::*;
#(
    parameter int IL = 64
) (
    input  logic          clk_48mhz,
    input  logic          reset_n,
    input  logic [7:0]    cmd_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    output logic [IL-1:0] rx_vec,
    output logic          rx_seen,
    output logic [7:0]    rx_err_cnt
);

    // IL never exceeds 128, so an 8-bit compare covers the full 7-bit index range.
    localparam logic [7:0] IL_LIM = 8'(IL);

    logic [7:0] idx;
    logic       val;
    logic       in_range;
    logic       accept;

    assign idx      = {1'b0, cmd_data[7:1]};
    assign val      = cmd_data[0];
    assign in_range = (idx < IL_LIM);
    assign accept   = cmd_valid & cmd_ready;

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            cmd_ready  <= 1'b0;
            rx_vec     <= '0;
            rx_seen    <= 1'b0;
            rx_err_cnt <= 8'd0;
        end else begin
            cmd_ready <= 1'b1;
            if (accept) begin
                if (in_range) begin
                    for (int i = 0; i < IL; i++) begin
                        if (idx == 8'(i)) begin
                            rx_vec[i] <= val;
                        end
                    end
                    rx_seen <= 1'b1;
                end else if (rx_err_cnt != 8'hFF) begin
                    rx_err_cnt <= rx_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bitvec_uart_framer.sv
// ---------------------------------------------------------------------------
// bitvec_uart_framer
// Streams a snapshot of tx_vec to the host as ASCII '0'/'1' bytes (bit 0
// first) followed by '*', and applies host command bytes to rx_vec through
// bitvec_rx_decoder. TX and RX run independently.
//   clk_48mhz      in   clock, rising edge
//   reset_n        in   synchronous active-low reset
//   tx_vec         in   OL-bit vector reported to the host
//   uart_in_data   out  byte toward the USB serial core
//   uart_in_valid  out  uart_in_data valid
//   uart_in_ready  in   core accepts the byte
//   uart_out_data  in   command byte from the host
//   uart_out_valid in   command byte valid
//   uart_out_ready out  command byte accepted
//   rx_vec         out  IL-bit vector written by host commands
//   rx_seen        out  sticky legal-command flag
//   rx_err_cnt     out  saturating out-of-range command count
//   frame_done     out  one-cycle pulse after the terminator is accepted
// Optional feature: define FRAMER_CHANGE_ONLY_EN to send a new frame only
// when tx_vec differs from the last transmitted snapshot (the first frame
// after reset is always sent). Undefined: frames run back-to-back.
// ---------------------------------------------------------------------------
module bitvec_uart_framer
    import framer_pkg::*;
#(
    parameter int IL = 64,
    parameter int OL = 64
) (
    input  logic          clk_48mhz,
    input  logic          reset_n,
    input  logic [OL-1:0] tx_vec,
    output logic [7:0]    uart_in_data,
    output logic          uart_in_valid,
    input  logic          uart_in_ready,
    input  logic [7:0]    uart_out_data,
    input  logic          uart_out_valid,
    output logic          uart_out_ready,
    output logic [IL-1:0] rx_vec,
    output logic          rx_seen,
    output logic [7:0]    rx_err_cnt,
    output logic          frame_done
);

    localparam logic [CUR_W-1:0] LAST_BIT = CUR_W'(OL - 1);

    tx_state_t        state;
    logic [CUR_W-1:0] cursor;
    logic [CUR_W-1:0] cursor_nxt;
    logic [OL-1:0]    snap;
    logic [OL-1:0]    snap_shift;
    logic             armed;
    logic             accept;
    logic             start;

    assign accept     = uart_in_valid & uart_in_ready;
    assign cursor_nxt = cursor + 16'd1;
    // Shift instead of a variable bit-select so the index width is free.
    assign snap_shift = snap >> cursor_nxt;

    // armed delays the first frame by one edge after reset release.
`ifdef FRAMER_CHANGE_ONLY_EN
    logic sent_once;
    assign start = (state == ST_IDLE) && armed && (!sent_once || (tx_vec != snap));
`else
    assign start = (state == ST_IDLE) && armed;
`endif

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cursor        <= '0;
            snap          <= '0;
            armed         <= 1'b0;
            uart_in_data  <= 8'd0;
            uart_in_valid <= 1'b0;
            frame_done    <= 1'b0;
`ifdef FRAMER_CHANGE_ONLY_EN
            sent_once     <= 1'b0;
`endif
        end else begin
            armed      <= 1'b1;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap          <= tx_vec;
                        uart_in_data  <= bit_chr(tx_vec[0]);
                        uart_in_valid <= 1'b1;
                        cursor        <= '0;
                        state         <= ST_BITS;
                    end
                end
                ST_BITS: begin
                    if (accept) begin
                        if (cursor == LAST_BIT) begin
                            uart_in_data <= CHR_TERM;
                            cursor       <= '0;
                            state        <= ST_TERM;
                        end else begin
                            uart_in_data <= bit_chr(snap_shift[0]);
                            cursor       <= cursor_nxt;
                        end
                    end
                end
                ST_TERM: begin
                    if (accept) begin
                        uart_in_valid <= 1'b0;
                        frame_done    <= 1'b1;
                        state         <= ST_IDLE;
`ifdef FRAMER_CHANGE_ONLY_EN
                        sent_once     <= 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bitvec_rx_decoder #(
        .IL(IL)
    ) u_rx (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .cmd_data   (uart_out_data),
        .cmd_valid  (uart_out_valid),
        .cmd_ready  (uart_out_ready),
        .rx_vec     (rx_vec),
        .rx_seen    (rx_seen),
        .rx_err_cnt (rx_err_cnt)
    );

endmodule

// File: tb/tb_bitvec_uart_framer.sv
module tb_bitvec_uart_framer;

    logic        clk_48mhz = 1'b0;
    logic        reset_n;
    logic [3:0]  tx_vec;
    logic [7:0]  uart_in_data;
    logic        uart_in_valid;
    logic        uart_in_ready;
    logic [7:0]  uart_out_data;
    logic        uart_out_valid;
    logic        uart_out_ready;
    logic [63:0] rx_vec;
    logic        rx_seen;
    logic [7:0]  rx_err_cnt;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    bitvec_uart_framer #(
        .IL(64),
        .OL(4)
    ) dut (
        .clk_48mhz      (clk_48mhz),
        .reset_n        (reset_n),
        .tx_vec         (tx_vec),
        .uart_in_data   (uart_in_data),
        .uart_in_valid  (uart_in_valid),
        .uart_in_ready  (uart_in_ready),
        .uart_out_data  (uart_out_data),
        .uart_out_valid (uart_out_valid),
        .uart_out_ready (uart_out_ready),
        .rx_vec         (rx_vec),
        .rx_seen        (rx_seen),
        .rx_err_cnt     (rx_err_cnt),
        .frame_done     (frame_done)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        tx_vec         = 4'b1010;
        uart_in_ready  = 1'b1;
        uart_out_valid = 1'b0;
        uart_out_data  = 8'd0;
        repeat (3) tick();
        checks++;
        if ({uart_in_valid, uart_in_data, uart_out_ready, frame_done} !== 11'd0) begin
            failures++;
            $display("FAIL reset_tx got valid=%0d data=%0d ordy=%0d fd=%0d want all 0",
                     uart_in_valid, uart_in_data, uart_out_ready, frame_done);
        end
        checks++;
        if ({rx_vec, rx_seen, rx_err_cnt} !== 73'd0) begin
            failures++;
            $display("FAIL reset_rx got rx_vec=%h seen=%0d err=%0d want 0", rx_vec, rx_seen, rx_err_cnt);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (uart_in_valid !== 1'b0 || uart_out_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_edge1 got valid=%0d ordy=%0d want valid=0 ordy=1",
                     uart_in_valid, uart_out_ready);
        end
        tick();
        checks++;
        if ({uart_in_valid, uart_in_data} !== {1'b1, 8'd48}) begin
            failures++;
            $display("FAIL release_edge2 got valid=%0d data=%0d want valid=1 data=48",
                     uart_in_valid, uart_in_data);
        end
    endtask

    task automatic test_frame;
        logic [7:0] exp [5];
        exp = '{8'd48, 8'd49, 8'd48, 8'd49, 8'd42};
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({uart_in_valid, uart_in_data, frame_done} !== {1'b1, exp[k], 1'b0}) begin
                failures++;
                $display("FAIL frame_byte%0d got valid=%0d data=%0d fd=%0d want valid=1 data=%0d fd=0",
                         k, uart_in_valid, uart_in_data, frame_done, exp[k]);
            end
            tick();
        end
        checks++;
        if ({uart_in_valid, frame_done} !== 2'b01) begin
            failures++;
            $display("FAIL frame_idle got valid=%0d fd=%0d want valid=0 fd=1", uart_in_valid, frame_done);
        end
        tick();
        checks++;
        if ({uart_in_valid, uart_in_data, frame_done} !== {1'b1, 8'd48, 1'b0}) begin
            failures++;
            $display("FAIL frame_restart got valid=%0d data=%0d fd=%0d want valid=1 data=48 fd=0",
                     uart_in_valid, uart_in_data, frame_done);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] tail [3];
        tail = '{8'd49, 8'd42, 8'd0};
        tick();
        checks++;
        if ({uart_in_valid, uart_in_data} !== {1'b1, 8'd49}) begin
            failures++;
            $display("FAIL bp_byte1 got valid=%0d data=%0d want valid=1 data=49", uart_in_valid, uart_in_data);
        end
        tick();
        uart_in_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({uart_in_valid, uart_in_data} !== {1'b1, 8'd48}) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%0d data=%0d want valid=1 data=48",
                         k, uart_in_valid, uart_in_data);
            end
        end
        uart_in_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({uart_in_valid, uart_in_data} !== {1'b1, tail[k]}) begin
                failures++;
                $display("FAIL bp_tail%0d got valid=%0d data=%0d want valid=1 data=%0d",
                         k, uart_in_valid, uart_in_data, tail[k]);
            end
        end
        tick();
        checks++;
        if ({uart_in_valid, frame_done} !== 2'b01) begin
            failures++;
            $display("FAIL bp_idle got valid=%0d fd=%0d want valid=0 fd=1", uart_in_valid, frame_done);
        end
    endtask

    task automatic test_snapshot_change;
        logic [7:0] exp_old [5];
        logic [7:0] exp_new [5];
        exp_old = '{8'd48, 8'd49, 8'd48, 8'd49, 8'd42};
        exp_new = '{8'd49, 8'd48, 8'd49, 8'd48, 8'd42};
        tick();
        checks++;
        if ({uart_in_valid, uart_in_data} !== {1'b1, exp_old[0]}) begin
            failures++;
            $display("FAIL snap_old0 got valid=%0d data=%0d want valid=1 data=48", uart_in_valid, uart_in_data);
        end
        tx_vec = 4'b0101;
        for (int k = 1; k < 5; k++) begin
            tick();
            checks++;
            if ({uart_in_valid, uart_in_data} !== {1'b1, exp_old[k]}) begin
                failures++;
                $display("FAIL snap_old%0d got valid=%0d data=%0d want valid=1 data=%0d",
                         k, uart_in_valid, uart_in_data, exp_old[k]);
            end
        end
        tick();
        checks++;
        if (uart_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL snap_gap got valid=%0d want 0", uart_in_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({uart_in_valid, uart_in_data} !== {1'b1, exp_new[k]}) begin
                failures++;
                $display("FAIL snap_new%0d got valid=%0d data=%0d want valid=1 data=%0d",
                         k, uart_in_valid, uart_in_data, exp_new[k]);
            end
        end
        tick();
    endtask

    task automatic test_rx;
        int terms;
        uart_out_data = 8'h03; uart_out_valid = 1'b1; tick(); uart_out_valid = 1'b0;
        checks++;
        if ({rx_vec, rx_seen, rx_err_cnt} !== {64'h2, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL rx_set1 got rx_vec=%h seen=%0d err=%0d want 2/1/0", rx_vec, rx_seen, rx_err_cnt);
        end
        uart_out_data = 8'h80; uart_out_valid = 1'b1; tick(); uart_out_valid = 1'b0;
        checks++;
        if ({rx_vec, rx_seen, rx_err_cnt} !== {64'h2, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL rx_oob got rx_vec=%h seen=%0d err=%0d want 2/1/1", rx_vec, rx_seen, rx_err_cnt);
        end
        uart_out_data = 8'h7F; uart_out_valid = 1'b1; tick(); uart_out_valid = 1'b0;
        checks++;
        if (rx_vec !== 64'h8000_0000_0000_0002 || rx_err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rx_top_bit got rx_vec=%h err=%0d want 8000000000000002/1", rx_vec, rx_err_cnt);
        end
        uart_out_data = 8'h02; uart_out_valid = 1'b1; tick(); uart_out_valid = 1'b0;
        checks++;
        if ({rx_vec, rx_seen} !== {64'h8000_0000_0000_0000, 1'b1}) begin
            failures++;
            $display("FAIL rx_clear1 got rx_vec=%h seen=%0d want 8000000000000000/1", rx_vec, rx_seen);
        end
        // Saturation run; TX keeps framing 0101 every 6 cycles meanwhile.
        terms = 0;
        uart_out_data = 8'hFF; uart_out_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (uart_in_valid === 1'b1 && uart_in_data === 8'd42) terms++;
        end
        uart_out_valid = 1'b0;
        checks++;
        if (rx_err_cnt !== 8'd255 || rx_vec !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL rx_saturate got err=%0d rx_vec=%h want 255/8000000000000000", rx_err_cnt, rx_vec);
        end
        checks++;
        if (terms !== 50 || uart_out_ready !== 1'b1) begin
            failures++;
            $display("FAIL rx_tx_concurrent got terms=%0d ordy=%0d want terms=50 ordy=1", terms, uart_out_ready);
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] exp [5];
        bit found;
        exp = '{8'd49, 8'd48, 8'd49, 8'd48, 8'd42};
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (uart_in_valid === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mr_wait_idle got no idle cycle within 20 want idle");
        end
        repeat (3) tick();
        checks++;
        if ({uart_in_valid, uart_in_data} !== {1'b1, 8'd49}) begin
            failures++;
            $display("FAIL mr_bit2 got valid=%0d data=%0d want valid=1 data=49", uart_in_valid, uart_in_data);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({uart_in_valid, uart_in_data, frame_done} !== 10'd0) begin
            failures++;
            $display("FAIL mr_abort got valid=%0d data=%0d fd=%0d want 0/0/0", uart_in_valid, uart_in_data, frame_done);
        end
        checks++;
        if ({rx_vec, rx_seen, rx_err_cnt, uart_out_ready} !== 74'd0) begin
            failures++;
            $display("FAIL mr_rx_clear got rx_vec=%h seen=%0d err=%0d ordy=%0d want 0",
                     rx_vec, rx_seen, rx_err_cnt, uart_out_ready);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (uart_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL mr_release1 got valid=%0d want 0", uart_in_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({uart_in_valid, uart_in_data} !== {1'b1, exp[k]}) begin
                failures++;
                $display("FAIL mr_restart%0d got valid=%0d data=%0d want valid=1 data=%0d",
                         k, uart_in_valid, uart_in_data, exp[k]);
            end
        end
    endtask

    task automatic test_change_only;
        int terms;
        terms = 0;
        for (int k = 0; k < 60; k++) begin
            if (uart_in_valid === 1'b1 && uart_in_data === 8'd42) terms++;
            tick();
        end
        checks++;
        if (terms !== 1 || uart_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL co_const got terms=%0d valid=%0d want terms=1 valid=0", terms, uart_in_valid);
        end
        tx_vec = 4'b1011;
        terms = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (uart_in_valid === 1'b1 && uart_in_data === 8'd42) terms++;
        end
        checks++;
        if (terms !== 1 || uart_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL co_toggle got terms=%0d valid=%0d want terms=1 valid=0", terms, uart_in_valid);
        end
    endtask

    initial begin
        test_reset();
`ifdef FRAMER_CHANGE_ONLY_EN
        test_change_only();
`else
        test_frame();
        test_backpressure();
        test_snapshot_change();
        test_rx();
        test_mid_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
